// File: rtl/cache_ctrl_fsm.sv
// Sequencing controller for a 2-way, 8-set, 256-bit-line write-back data cache.
// Resolves hits, writes back dirty LRU victims, refills from memory and counts hits/misses.
module cache_ctrl_fsm #(
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               cpu_req,
  input  logic               cpu_we,
  input  logic [31:0]        cpu_addr,
  input  logic [31:0]        cpu_wdata,
  output logic [31:0]        cpu_rdata,
  output logic               cpu_ack,
  output logic               cpu_err,
  output logic               cpu_busy,
  output logic [31:0]        c_addr,
  output logic [31:0]        c_data_in,
  output logic [255:0]       c_line_in,
  input  logic               c_hit,
  input  logic               c_lru_valid,
  input  logic               c_lru_dirty,
  input  logic [25:0]        c_lru_tag,
  input  logic [255:0]       c_victim_line,
  input  logic [31:0]        c_data_out,
  output logic               c_update_lru,
  output logic               c_update_tag,
  output logic               c_set_dirty,
  output logic               c_clear_dirty,
  output logic               c_set_valid,
  output logic               c_clear_valid,
  output logic               c_word_we,
  output logic               c_line_we,
  output logic               mem_rd_req,
  output logic               mem_wr_req,
  output logic [28:0]        mem_line_addr,
  output logic [255:0]       mem_wdata,
  input  logic [255:0]       mem_rdata,
  input  logic               mem_ack,
  output logic [CNT_W-1:0]   hit_cnt,
  output logic [CNT_W-1:0]   miss_cnt
);

  localparam int unsigned TmoW = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [2:0] {
    StIdle,
    StLookup,
    StCompare,
    StWriteback,
    StAllocate
  } state_e;

  state_e            state_q, state_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              we_q, we_d;
  logic              ack_q, ack_d;
  logic              err_q, err_d;
  logic              refill_q, refill_d;
  logic [CNT_W-1:0]  hit_cnt_q, hit_cnt_d;
  logic [CNT_W-1:0]  miss_cnt_q, miss_cnt_d;
  logic [TmoW-1:0]   tmo_q, tmo_d;
  logic [TmoW-1:0]   tmo_inc;
  logic              tmo_hit;

  assign tmo_inc = tmo_q + TmoW'(1);
  assign tmo_hit = (tmo_inc == TmoW'(MEM_TIMEOUT));

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    rdata_d       = rdata_q;
    we_d          = we_q;
    ack_d         = 1'b0;
    err_d         = 1'b0;
    refill_d      = refill_q;
    hit_cnt_d     = hit_cnt_q;
    miss_cnt_d    = miss_cnt_q;
    tmo_d         = tmo_q;
    c_update_lru  = 1'b0;
    c_update_tag  = 1'b0;
    c_set_dirty   = 1'b0;
    c_clear_dirty = 1'b0;
    c_set_valid   = 1'b0;
    c_clear_valid = 1'b0;
    c_word_we     = 1'b0;
    c_line_we     = 1'b0;
    c_line_in     = '0;
    mem_rd_req    = 1'b0;
    mem_wr_req    = 1'b0;
    mem_line_addr = '0;
    mem_wdata     = '0;

    unique case (state_q)
      StIdle: begin
        if (cpu_req) begin
          addr_d   = cpu_addr;
          we_d     = cpu_we;
          wdata_d  = cpu_wdata;
          refill_d = 1'b0;
          state_d  = StLookup;
        end
      end
      StLookup: state_d = StCompare;
      StCompare: begin
        if (c_hit) begin
          c_update_lru = 1'b1;
          c_word_we    = we_q;
          c_set_dirty  = we_q;
          ack_d        = 1'b1;
          rdata_d      = c_data_out;
          // The re-check after a refill was already counted as a miss.
          if (!refill_q) hit_cnt_d = hit_cnt_q + CNT_W'(1);
          state_d = StIdle;
        end else begin
          if (!refill_q) miss_cnt_d = miss_cnt_q + CNT_W'(1);
          tmo_d   = '0;
          state_d = (c_lru_valid && c_lru_dirty) ? StWriteback : StAllocate;
        end
      end
      StWriteback: begin
        mem_wr_req    = 1'b1;
        mem_line_addr = {c_lru_tag, addr_q[5:3]};
        mem_wdata     = c_victim_line;
        if (mem_ack) begin
          c_clear_dirty = 1'b1;
          tmo_d         = '0;
          state_d       = StAllocate;
        end else if (tmo_hit) begin
          ack_d   = 1'b1;
          err_d   = 1'b1;
          state_d = StIdle;
        end else begin
          tmo_d = tmo_inc;
        end
      end
      StAllocate: begin
        mem_rd_req    = 1'b1;
        mem_line_addr = addr_q[31:3];
        c_line_in     = mem_rdata;
        if (mem_ack) begin
          c_line_we     = 1'b1;
          c_update_tag  = 1'b1;
          c_set_valid   = 1'b1;
          c_clear_dirty = 1'b1;
          refill_d      = 1'b1;
          state_d       = StLookup;
        end else if (tmo_hit) begin
          ack_d   = 1'b1;
          err_d   = 1'b1;
          state_d = StIdle;
        end else begin
          tmo_d = tmo_inc;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      we_q       <= 1'b0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      refill_q   <= 1'b0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      tmo_q      <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      we_q       <= we_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      refill_q   <= refill_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
      tmo_q      <= tmo_d;
    end
  end

  assign cpu_rdata = rdata_q;
  assign cpu_ack   = ack_q;
  assign cpu_err   = err_q;
  assign cpu_busy  = (state_q != StIdle);
  assign c_addr    = addr_q;
  assign c_data_in = wdata_q;
  assign hit_cnt   = hit_cnt_q;
  assign miss_cnt  = miss_cnt_q;

endmodule

// File: tb/tb_cache_ctrl_fsm.sv
// Bench for cache_ctrl_fsm: behavioural 2-way cache arrays and line memory around the DUT,
// with a scoreboard of expected load results popped on every cpu_ack.
module tb_cache_ctrl_fsm;

  localparam int MemLat = 3;

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic         cpu_req = 1'b0;
  logic         cpu_we = 1'b0;
  logic [31:0]  cpu_addr = '0;
  logic [31:0]  cpu_wdata = '0;
  logic [31:0]  cpu_rdata;
  logic         cpu_ack, cpu_err, cpu_busy;
  logic [31:0]  c_addr, c_data_in;
  logic [255:0] c_line_in;
  logic         c_hit, c_lru_valid, c_lru_dirty;
  logic [25:0]  c_lru_tag;
  logic [255:0] c_victim_line;
  logic [31:0]  c_data_out;
  logic         c_update_lru, c_update_tag, c_set_dirty, c_clear_dirty;
  logic         c_set_valid, c_clear_valid, c_word_we, c_line_we;
  logic         mem_rd_req, mem_wr_req;
  logic [28:0]  mem_line_addr;
  logic [255:0] mem_wdata, mem_rdata;
  logic         mem_ack;
  logic [31:0]  hit_cnt, miss_cnt;

  cache_ctrl_fsm #(.CNT_W(32), .MEM_TIMEOUT(255)) dut (
    .CLK(CLK), .RST(RST), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_err(cpu_err),
    .cpu_busy(cpu_busy), .c_addr(c_addr), .c_data_in(c_data_in), .c_line_in(c_line_in),
    .c_hit(c_hit), .c_lru_valid(c_lru_valid), .c_lru_dirty(c_lru_dirty),
    .c_lru_tag(c_lru_tag), .c_victim_line(c_victim_line), .c_data_out(c_data_out),
    .c_update_lru(c_update_lru), .c_update_tag(c_update_tag), .c_set_dirty(c_set_dirty),
    .c_clear_dirty(c_clear_dirty), .c_set_valid(c_set_valid), .c_clear_valid(c_clear_valid),
    .c_word_we(c_word_we), .c_line_we(c_line_we), .mem_rd_req(mem_rd_req),
    .mem_wr_req(mem_wr_req), .mem_line_addr(mem_line_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [31:0] data;
    bit          chk;
    bit          err;
  } exp_t;
  exp_t sb[$];
  logic [31:0] shadow [logic [31:0]];

  bit cache_clr = 1'b1;
  bit withhold  = 1'b0;
  bit strobe_clash = 1'b0;

  function automatic logic [31:0] pat(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5EED_0000;
  endfunction

  function automatic logic [255:0] line_pat(input logic [28:0] la);
    logic [255:0] l;
    for (int w = 0; w < 8; w++) l[w*32 +: 32] = pat({la, 3'(w)});
    return l;
  endfunction

  function automatic logic [31:0] get_word(input logic [255:0] l, input logic [2:0] o);
    return l[{o, 5'd0} +: 32];
  endfunction

  function automatic logic [255:0] put_word(input logic [255:0] l, input logic [2:0] o,
                                            input logic [31:0] w);
    logic [255:0] r;
    r = l;
    r[{o, 5'd0} +: 32] = w;
    return r;
  endfunction

  function automatic logic [31:0] exp_word(input logic [31:0] a);
    return shadow.exists(a) ? shadow[a] : pat(a);
  endfunction

  // Behavioural cache arrays: registered read outputs, writes on strobes.
  logic [25:0]  m_tag  [2][8];
  logic         m_val  [2][8];
  logic         m_dirty[2][8];
  logic [255:0] m_data [2][8];
  logic         m_lru  [8];
  logic [2:0]   m_idx, m_off;
  logic [25:0]  m_tg;
  logic         m_h0, m_h1, m_hw, m_lw;

  assign m_idx = c_addr[5:3];
  assign m_off = c_addr[2:0];
  assign m_tg  = c_addr[31:6];
  assign m_h0  = m_val[0][m_idx] && (m_tag[0][m_idx] == m_tg);
  assign m_h1  = m_val[1][m_idx] && (m_tag[1][m_idx] == m_tg);
  assign m_hw  = m_h1;
  assign m_lw  = m_lru[m_idx];

  always @(posedge CLK) begin
    if (cache_clr) begin
      for (int w = 0; w < 2; w++) begin
        for (int s = 0; s < 8; s++) begin
          m_val[w][s]   <= 1'b0;
          m_dirty[w][s] <= 1'b0;
          m_tag[w][s]   <= '0;
          m_data[w][s]  <= '0;
        end
      end
      for (int s = 0; s < 8; s++) m_lru[s] <= 1'b0;
    end else begin
      c_hit         <= m_h0 | m_h1;
      c_data_out    <= get_word(m_data[m_hw][m_idx], m_off);
      c_lru_valid   <= m_val[m_lw][m_idx];
      c_lru_dirty   <= m_dirty[m_lw][m_idx];
      c_lru_tag     <= m_tag[m_lw][m_idx];
      c_victim_line <= m_data[m_lw][m_idx];
      if (c_word_we) m_data[m_hw][m_idx] <= put_word(m_data[m_hw][m_idx], m_off, c_data_in);
      if (c_set_dirty) m_dirty[m_hw][m_idx] <= 1'b1;
      if (c_update_lru) m_lru[m_idx] <= ~m_hw;
      if (c_line_we) m_data[m_lw][m_idx] <= c_line_in;
      if (c_update_tag) m_tag[m_lw][m_idx] <= m_tg;
      if (c_set_valid) m_val[m_lw][m_idx] <= 1'b1;
      if (c_clear_valid) m_val[m_lw][m_idx] <= 1'b0;
      if (c_clear_dirty) m_dirty[m_lw][m_idx] <= 1'b0;
    end
  end

  // Line memory answering after MemLat request cycles, unless withheld.
  logic [255:0] m_mem [128];
  int           m_cnt;

  always @(posedge CLK) begin
    if (cache_clr) begin
      for (int i = 0; i < 128; i++) m_mem[i] <= line_pat(29'(i));
      mem_ack   <= 1'b0;
      mem_rdata <= '0;
      m_cnt     <= 0;
    end else if (RST || mem_ack) begin
      mem_ack <= 1'b0;
      m_cnt   <= 0;
    end else if ((mem_rd_req || mem_wr_req) && !withhold) begin
      if (m_cnt == MemLat - 1) begin
        mem_ack <= 1'b1;
        if (mem_rd_req) mem_rdata <= m_mem[mem_line_addr[6:0]];
        if (mem_wr_req) m_mem[mem_line_addr[6:0]] <= mem_wdata;
      end else begin
        m_cnt <= m_cnt + 1;
      end
    end else begin
      m_cnt <= 0;
    end
  end

  // Scoreboard consumer: every cpu_ack must match the oldest outstanding request.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge CLK);
      if ((c_set_dirty && c_clear_dirty) || (c_set_valid && c_clear_valid)) strobe_clash = 1'b1;
      if (RST) begin
        sb.delete();
      end else if (cpu_ack === 1'b1) begin
        n_tests++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_ack: cpu_ack=1 with no request outstanding");
        end else begin
          e = sb.pop_front();
          if (cpu_err !== e.err) begin
            n_fail++;
            $display("FAIL ack_err: got %b, expected %b", cpu_err, e.err);
          end
          if (e.chk) begin
            n_tests++;
            if (cpu_rdata !== e.data) begin
              n_fail++;
              $display("FAIL ack_rdata: got %h, expected %h", cpu_rdata, e.data);
            end
          end
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Per-transaction observations gathered while waiting for cpu_ack.
  bit          saw_rd, saw_wr, saw_set_valid;
  logic [28:0] rd_addr, wr_addr;
  logic [31:0] wr_word1;
  int          rd_cycles, busy_low;

  task automatic push_exp(input logic [31:0] a, input logic we, input logic [31:0] wd,
                          input bit err);
    exp_t e;
    e.data = exp_word(a);
    e.chk  = !err;
    e.err  = err;
    sb.push_back(e);
    if (we && !err) shadow[a] = wd;
  endtask

  // Called at a negedge with the DUT idle; returns one negedge after the accepting edge.
  task automatic send(input logic [31:0] a, input logic we, input logic [31:0] wd,
                      input bit err);
    cpu_req = 1'b1;
    cpu_addr = a;
    cpu_we = we;
    cpu_wdata = wd;
    push_exp(a, we, wd, err);
    @(negedge CLK);
    cpu_req = 1'b0;
  endtask

  task automatic observe();
    if (mem_rd_req === 1'b1) begin
      if (!saw_rd) rd_addr = mem_line_addr;
      saw_rd = 1'b1;
      rd_cycles++;
    end
    if (mem_wr_req === 1'b1) begin
      if (!saw_wr) begin
        wr_addr  = mem_line_addr;
        wr_word1 = mem_wdata[63:32];
      end
      saw_wr = 1'b1;
    end
    if (c_set_valid === 1'b1) saw_set_valid = 1'b1;
    if (cpu_busy !== 1'b1) busy_low++;
  endtask

  task automatic run_txn(input int maxc, output int cyc);
    saw_rd = 0; saw_wr = 0; saw_set_valid = 0;
    rd_addr = '0; wr_addr = '0; wr_word1 = '0;
    rd_cycles = 0; busy_low = 0;
    cyc = 0;
    while (cpu_ack !== 1'b1 && cyc < maxc) begin
      observe();
      @(negedge CLK);
      cyc++;
    end
    n_tests++;
    if (cpu_ack !== 1'b1) begin
      n_fail++;
      $display("FAIL ack_timeout: no cpu_ack within %0d cycles", maxc);
    end
  endtask

  task automatic test_reset();
    n_tests++;
    if ({cpu_ack, cpu_err, cpu_busy} !== 3'b000) begin
      n_fail++; $display("FAIL reset_flags: ack/err/busy=%b, expected 000",
                         {cpu_ack, cpu_err, cpu_busy});
    end
    n_tests++;
    if (hit_cnt !== 32'd0 || miss_cnt !== 32'd0) begin
      n_fail++; $display("FAIL reset_cnt: hit=%0d miss=%0d, expected 0", hit_cnt, miss_cnt);
    end
    n_tests++;
    if (cpu_rdata !== 32'd0 || c_addr !== 32'd0 || c_data_in !== 32'd0) begin
      n_fail++; $display("FAIL reset_latch: rdata=%h addr=%h data=%h, expected 0",
                         cpu_rdata, c_addr, c_data_in);
    end
    n_tests++;
    if ({mem_rd_req, mem_wr_req} !== 2'b00 || mem_line_addr !== 29'd0) begin
      n_fail++; $display("FAIL reset_mem: rd=%b wr=%b addr=%h, expected 0",
                         mem_rd_req, mem_wr_req, mem_line_addr);
    end
  endtask

  task automatic test_cold_miss();
    int cyc;
    send(32'h40, 1'b0, 32'h0, 1'b0);
    run_txn(60, cyc);
    n_tests++;
    if (saw_rd !== 1'b1 || rd_addr !== 29'h8) begin
      n_fail++; $display("FAIL cold_alloc_addr: saw_rd=%b addr=%h, expected 1/8", saw_rd, rd_addr);
    end
    n_tests++;
    if (saw_wr !== 1'b0) begin
      n_fail++; $display("FAIL cold_no_wb: saw_wr=%b, expected 0", saw_wr);
    end
    n_tests++;
    if (miss_cnt !== 32'd1 || hit_cnt !== 32'd0) begin
      n_fail++; $display("FAIL cold_cnt: hit=%0d miss=%0d, expected 0/1", hit_cnt, miss_cnt);
    end
  endtask

  task automatic test_hit();
    int cyc;
    send(32'h40, 1'b0, 32'h0, 1'b0);
    run_txn(20, cyc);
    n_tests++;
    if (cyc != 2) begin
      n_fail++; $display("FAIL hit_latency: %0d cycles, expected 2", cyc);
    end
    n_tests++;
    if (saw_rd || saw_wr) begin
      n_fail++; $display("FAIL hit_no_mem: rd=%b wr=%b, expected 0/0", saw_rd, saw_wr);
    end
    n_tests++;
    if (hit_cnt !== 32'd1 || miss_cnt !== 32'd1) begin
      n_fail++; $display("FAIL hit_cnt: hit=%0d miss=%0d, expected 1/1", hit_cnt, miss_cnt);
    end
  endtask

  task automatic test_writeback();
    int cyc;
    send(32'h41, 1'b1, 32'hCAFE_F00D, 1'b0);
    run_txn(20, cyc);
    n_tests++;
    if (saw_rd) begin
      n_fail++; $display("FAIL store_hit_no_mem: saw_rd=%b, expected 0", saw_rd);
    end
    send(32'h80, 1'b0, 32'h0, 1'b0);
    run_txn(60, cyc);
    n_tests++;
    if (saw_wr !== 1'b0 || rd_addr !== 29'h10) begin
      n_fail++; $display("FAIL fill_way1: wr=%b rd_addr=%h, expected 0/10", saw_wr, rd_addr);
    end
    send(32'hC0, 1'b0, 32'h0, 1'b0);
    run_txn(80, cyc);
    n_tests++;
    if (saw_wr !== 1'b1 || wr_addr !== 29'h8 || wr_word1 !== 32'hCAFE_F00D) begin
      n_fail++; $display("FAIL wb_victim: wr=%b addr=%h word1=%h, expected 1/8/cafef00d",
                         saw_wr, wr_addr, wr_word1);
    end
    n_tests++;
    if (rd_addr !== 29'h18) begin
      n_fail++; $display("FAIL wb_then_alloc: rd_addr=%h, expected 18", rd_addr);
    end
    send(32'h41, 1'b0, 32'h0, 1'b0);
    run_txn(60, cyc);
    n_tests++;
    if (miss_cnt !== 32'd4 || hit_cnt !== 32'd2) begin
      n_fail++; $display("FAIL wb_cnt: hit=%0d miss=%0d, expected 2/4", hit_cnt, miss_cnt);
    end
  endtask

  task automatic test_timeout();
    int cyc;
    withhold = 1'b1;
    send(32'h100, 1'b0, 32'h0, 1'b1);
    run_txn(400, cyc);
    n_tests++;
    if (rd_cycles != 255) begin
      n_fail++; $display("FAIL tmo_len: rd_req high %0d cycles, expected 255", rd_cycles);
    end
    n_tests++;
    if (saw_set_valid) begin
      n_fail++; $display("FAIL tmo_no_strobe: c_set_valid seen, expected none");
    end
    n_tests++;
    if (cpu_busy !== 1'b0 || mem_rd_req !== 1'b0) begin
      n_fail++; $display("FAIL tmo_idle: busy=%b rd_req=%b, expected 0/0", cpu_busy, mem_rd_req);
    end
    @(negedge CLK);
    n_tests++;
    if (cpu_ack !== 1'b0 || cpu_err !== 1'b0) begin
      n_fail++; $display("FAIL tmo_pulse: ack=%b err=%b one cycle later, expected 0/0",
                         cpu_ack, cpu_err);
    end
    n_tests++;
    if (miss_cnt !== 32'd5) begin
      n_fail++; $display("FAIL tmo_cnt: miss=%0d, expected 5", miss_cnt);
    end
    withhold = 1'b0;
  endtask

  task automatic test_reset_mid();
    int cyc;
    int k;
    withhold = 1'b1;
    send(32'h200, 1'b0, 32'h0, 1'b0);
    k = 0;
    while (mem_rd_req !== 1'b1 && k < 20) begin
      @(negedge CLK);
      k++;
    end
    n_tests++;
    if (mem_rd_req !== 1'b1) begin
      n_fail++; $display("FAIL rst_mid_alloc: rd_req=%b, expected 1", mem_rd_req);
    end
    RST = 1'b1;
    #1;
    n_tests++;
    if (mem_rd_req !== 1'b0 || cpu_busy !== 1'b0) begin
      n_fail++; $display("FAIL rst_drop: rd_req=%b busy=%b, expected 0/0", mem_rd_req, cpu_busy);
    end
    n_tests++;
    if (hit_cnt !== 32'd0 || miss_cnt !== 32'd0) begin
      n_fail++; $display("FAIL rst_cnt: hit=%0d miss=%0d, expected 0", hit_cnt, miss_cnt);
    end
    repeat (2) @(negedge CLK);
    withhold = 1'b0;
    RST = 1'b0;
    @(negedge CLK);
    send(32'h200, 1'b0, 32'h0, 1'b0);
    run_txn(60, cyc);
    n_tests++;
    if (miss_cnt !== 32'd1 || hit_cnt !== 32'd0 || rd_addr !== 29'h40) begin
      n_fail++; $display("FAIL rst_recover: hit=%0d miss=%0d rd_addr=%h, expected 0/1/40",
                         hit_cnt, miss_cnt, rd_addr);
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    logic [31:0] h0, m0;
    h0 = hit_cnt;
    m0 = miss_cnt;
    cpu_req = 1'b1;
    cpu_addr = 32'h300;
    cpu_we = 1'b0;
    cpu_wdata = 32'h0;
    push_exp(32'h300, 1'b0, 32'h0, 1'b0);
    @(negedge CLK);
    // Request stays high with new contents; none of it may be taken until IDLE.
    cpu_addr = 32'h5C8;
    cpu_we = 1'b1;
    cpu_wdata = 32'hDEAD_BEEF;
    run_txn(60, cyc);
    cpu_req = 1'b0;
    repeat (6) @(negedge CLK);
    n_tests++;
    if (busy_low != 0) begin
      n_fail++; $display("FAIL b2b_busy: busy low %0d cycles during miss, expected 0", busy_low);
    end
    n_tests++;
    if (rd_addr !== 29'h60) begin
      n_fail++; $display("FAIL b2b_addr: rd_addr=%h, expected 60", rd_addr);
    end
    n_tests++;
    if (miss_cnt !== m0 + 32'd1 || hit_cnt !== h0) begin
      n_fail++; $display("FAIL b2b_cnt: hit=%0d miss=%0d, expected %0d/%0d",
                         hit_cnt, miss_cnt, h0, m0 + 32'd1);
    end
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++; $display("FAIL b2b_pending: %0d requests unanswered, expected 0", sb.size());
    end
  endtask

  task automatic test_strobes();
    n_tests++;
    if (strobe_clash) begin
      n_fail++; $display("FAIL strobe_pair: set and clear of a pair seen together, expected never");
    end
  endtask

  initial begin
    repeat (3) @(negedge CLK);
    cache_clr = 1'b0;
    RST = 1'b0;
    @(negedge CLK);
    test_reset();
    test_cold_miss();
    test_hit();
    test_writeback();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    test_strobes();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
